// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer
//   Write-side width-up packer feeding an async FIFO in the wr_clk domain.
//   Narrow beats (valid/ready, with an end-of-packet flag) are packed RATIO
//   at a time into one FIFO word. A packet end flushes a partial word early.
//   Each word carries a last flag and a lane count (number of lanes - 1).
//
// Ports
//   wr_clk, wr_rst_n : write clock, asynchronous active-low reset
//   in_valid/in_ready: input beat handshake
//   in_data, in_last : beat payload and end-of-packet flag
//   fifo_wr_en       : FIFO write strobe; never asserted while fifo_full=1
//   fifo_wr_data     : {last, nlanes_m1, data}; lane 0 is in the LSBs
//   fifo_full        : FIFO full flag, already registered in wr_clk
//   pkt_cnt          : count of last-flagged words written; wraps
module fifo_wr_packer #(
  parameter  int IN_WIDTH  = 4,
  parameter  int RATIO     = 4,
  parameter  int PKT_CNT_W = 16,
  localparam int LW        = $clog2(RATIO),
  localparam int FIFO_DW   = 1 + LW + IN_WIDTH * RATIO
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 fifo_wr_en,
  output logic [FIFO_DW-1:0]   fifo_wr_data,
  input  logic                 fifo_full,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  localparam int            AW       = IN_WIDTH * RATIO;
  localparam logic [LW-1:0] LANE_MAX = LW'(RATIO - 1);

  // Drop a beat into its lane slot of the accumulator image.
  function automatic logic [AW-1:0] merge_lane(input logic [AW-1:0]       a,
                                               input logic [LW-1:0]       l,
                                               input logic [IN_WIDTH-1:0] d);
    logic [AW-1:0] r;
    r = a;
    r[int'(l) * IN_WIDTH +: IN_WIDTH] = d;
    return r;
  endfunction

  logic [AW-1:0]      acc;
  logic [LW-1:0]      lane;
  logic [FIFO_DW-1:0] out_reg;
  logic               out_vld;

  logic               drain;
  logic               accept;
  logic               complete;
  logic [AW-1:0]      merged;

  // The holding register drains whenever the FIFO has room; a new beat may
  // enter in the same cycle, so a completed word can be replaced while the
  // old one is being written (full-rate back-to-back words).
  assign drain        = out_vld & ~fifo_full;
  assign in_ready     = ~out_vld | drain;
  assign accept       = in_valid & in_ready;
  assign complete     = accept & ((lane == LANE_MAX) | in_last);
  assign merged       = merge_lane(acc, lane, in_data);
  assign fifo_wr_en   = drain;
  assign fifo_wr_data = out_reg;

  // Accumulate beats; hand a completed word to the output register.
  // acc is cleared on every completion, so lanes above the last filled lane
  // are always zero in a flushed partial word.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      acc     <= '0;
      lane    <= '0;
      out_reg <= '0;
      out_vld <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      if (accept) begin
        if (complete) begin
          out_reg <= {in_last, lane, merged};
          acc     <= '0;
          lane    <= '0;
        end else begin
          acc     <= merged;
          lane    <= lane + LW'(1);
        end
      end

      if (complete)
        out_vld <= 1'b1;
      else if (drain)
        out_vld <= 1'b0;

      if (drain && out_reg[FIFO_DW-1])
        pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer
//   Directed bench for fifo_wr_packer with IN_WIDTH=4, RATIO=4.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   there too, and a negedge monitor logs FIFO writes and accepted beats.
module tb_fifo_wr_packer;

  localparam int IN_WIDTH  = 4;
  localparam int RATIO     = 4;
  localparam int PKT_CNT_W = 16;
  localparam int FIFO_DW   = 1 + 2 + IN_WIDTH * RATIO;

  logic                 wr_clk = 1'b0;
  logic                 wr_rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 fifo_wr_en;
  logic [FIFO_DW-1:0]   fifo_wr_data;
  logic                 fifo_full;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  logic [FIFO_DW-1:0] wq[$];
  int                 wcyc[$];
  int                 n_acc = 0;
  int                 cyc   = 0;

  fifo_wr_packer #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO),
    .PKT_CNT_W(PKT_CNT_W)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full   (fifo_full),
    .pkt_cnt     (pkt_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc <= cyc + 1;

  always @(negedge wr_clk) begin
    if (wr_rst_n) begin
      if (fifo_wr_en) begin
        wq.push_back(fifo_wr_data);
        wcyc.push_back(cyc);
      end
      if (in_valid && in_ready) n_acc = n_acc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FIFO_DW-1:0] word(input logic l, input logic [1:0] n,
                                              input logic [15:0] d);
    return {l, n, d};
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  // Present one beat for one cycle; caller guarantees in_ready is high.
  task automatic send(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_logs();
    wq.delete();
    wcyc.delete();
    n_acc = 0;
  endtask

  initial begin
    int idx;
    logic take;

    wr_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    fifo_full = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    wr_rst_n = 1'b1;
    tick();

    // 1: full word, no last
    for (int i = 1; i <= 4; i++) begin
      chk("t1_ready", 32'(in_ready), 32'd1);
      send(4'(i), 1'b0);
    end
    chk("t1_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t1_data", 32'(fifo_wr_data), 32'(word(1'b0, 2'd3, 16'h4321)));
    chk("t1_ready_out", 32'(in_ready), 32'd1);
    tick();
    chk("t1_wr_en_off", 32'(fifo_wr_en), 32'd0);

    // 2: two-beat packet, partial flush
    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    chk("t2_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t2_data", 32'(fifo_wr_data), 32'(word(1'b1, 2'd1, 16'h00BA)));
    chk("t2_cnt_before", 32'(pkt_cnt), 32'd0);
    tick();
    chk("t2_cnt_after", 32'(pkt_cnt), 32'd1);
    chk("t2_wr_en_off", 32'(fifo_wr_en), 32'd0);

    // 3: backpressure with 8 beats offered continuously
    clear_logs();
    fifo_full = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 4'(idx + 1);
      in_last  = 1'b0;
      #1;
      if (c >= 4) chk("t3_ready_low", 32'(in_ready), 32'd0);
      chk("t3_no_write", 32'(fifo_wr_en), 32'd0);
      take = in_ready;
      tick();
      if (take) idx = idx + 1;
    end
    chk("t3_held_beats", 32'(idx), 32'd4);
    chk("t3_held_data", 32'(fifo_wr_data), 32'(word(1'b0, 2'd3, 16'h4321)));
    fifo_full = 1'b0;
    in_data   = 4'(idx + 1);
    #1;
    chk("t3_release_wr", 32'(fifo_wr_en), 32'd1);
    chk("t3_release_data", 32'(fifo_wr_data), 32'(word(1'b0, 2'd3, 16'h4321)));
    chk("t3_release_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 20 && idx < 8; c++) begin
      in_data = 4'(idx + 1);
      #1;
      take = in_ready;
      tick();
      if (take) idx = idx + 1;
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t3_accepted", 32'(n_acc), 32'd8);
    chk("t3_nwords", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("t3_w0", 32'(wq[0]), 32'(word(1'b0, 2'd3, 16'h4321)));
      chk("t3_w1", 32'(wq[1]), 32'(word(1'b0, 2'd3, 16'h8765)));
    end

    // 4: 16 back-to-back beats
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i);
      in_last  = 1'b0;
      #1;
      chk("t4_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t4_nwords", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      chk("t4_w0", 32'(wq[0]), 32'(word(1'b0, 2'd3, 16'h3210)));
      chk("t4_w1", 32'(wq[1]), 32'(word(1'b0, 2'd3, 16'h7654)));
      chk("t4_w2", 32'(wq[2]), 32'(word(1'b0, 2'd3, 16'hBA98)));
      chk("t4_w3", 32'(wq[3]), 32'(word(1'b0, 2'd3, 16'hFEDC)));
      for (int i = 0; i < 3; i++)
        chk("t4_spacing", 32'(wcyc[i+1] - wcyc[i]), 32'd4);
    end

    // 5: single-beat packet immediately followed by a full word
    clear_logs();
    send(4'h7, 1'b1);
    chk("t5_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
    tick();
    chk("t5_nwords", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("t5_w0", 32'(wq[0]), 32'(word(1'b1, 2'd0, 16'h0007)));
      chk("t5_w1", 32'(wq[1]), 32'(word(1'b0, 2'd3, 16'h4321)));
    end
    chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // 6: reset mid-packet
    clear_logs();
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    wr_rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t6_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    tick();
    wr_rst_n = 1'b1;
    tick();
    for (int i = 5; i <= 8; i++) send(4'(i), 1'b0);
    chk("t6_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t6_data", 32'(fifo_wr_data), 32'(word(1'b0, 2'd3, 16'h8765)));
    tick();
    chk("t6_nwords", 32'(wq.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-side width-up packer that sits directly upstream of the async FIFO, in the wr_clk domain. It accepts a narrow valid/ready beat stream with an end-of-packet flag and packs RATIO beats into one FIFO word. Each word carries a last flag and a lane count, so partial words at packet end are flushed rather than held. It drives the FIFO write port and never writes while the FIFO reports full.

Parameters:
IN_WIDTH, 4, width of one input beat (lane).
RATIO, 4, beats per FIFO word; power of 2, at least 2.
LW (localparam), $clog2(RATIO), width of the lane-count field.
FIFO_DW (localparam), 1+LW+IN_WIDTH*RATIO, FIFO word width; connects to the FIFO DATA_WIDTH.
PKT_CNT_W, 16, width of the packet counter.

Ports:
wr_clk  in  1  write-domain clock.
wr_rst_n  in  1  write-domain reset, asynchronous, active-low.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid & in_ready.
in_data  in  IN_WIDTH  input beat.
in_last  in  1  beat is the last of its packet.
fifo_wr_en  out  1  FIFO write strobe.
fifo_wr_data  out  FIFO_DW  {last, nlanes_m1[LW-1:0], data[IN_WIDTH*RATIO-1:0]}.
fifo_full  in  1  FIFO full flag, registered in the wr_clk domain.
pkt_cnt  out  PKT_CNT_W  number of last-flagged words written to the FIFO; wraps.

Behaviour:
- State:
  - acc: data accumulator.
  - lane: 0..RATIO-1, the next lane to fill.
  - out_reg / out_vld: single output holding register and its valid bit.
- Reset, asynchronous: acc=0, lane=0, out_vld=0, out_reg=0, pkt_cnt=0. So fifo_wr_en=0, fifo_wr_data=0, in_ready=1.
- drain = out_vld & ~fifo_full.
- fifo_wr_en = drain, combinational from registers. fifo_wr_data = out_reg.
- in_ready = ~out_vld | drain. in_ready never depends on in_valid, in_data or in_last.
- accept = in_valid & in_ready.
- Lane packing: lane 0 is the LSBs, i.e. beat k lands in data[k*IN_WIDTH +: IN_WIDTH].
- Accept without completion (lane<RATIO-1 and !in_last):
  - acc lane slot <= in_data.
  - lane <= lane+1.
- Accept with completion (lane==RATIO-1 or in_last):
  - out_reg <= {in_last, lane, acc merged with in_data at slot lane}. Lanes above lane are zero.
  - out_vld <= 1; acc <= 0; lane <= 0.
- out_vld update:
  - drain with no completion in the same cycle: out_vld <= 0.
  - drain and completion in the same cycle: out_reg is reloaded and out_vld stays 1. This is back-to-back, full rate.
- Latency: a completing beat accepted at cycle t gives fifo_wr_en at t+1 if fifo_full=0 at t+1. Otherwise the word is held, stable, until fifo_full=0.
- Backpressure:
  - While out_vld & fifo_full, in_ready=0 and acc/lane are frozen.
  - No beat is dropped; no write is issued while fifo_full=1.
- Packet counter: pkt_cnt increments on every drain whose word has last=1. Wraps modulo 2^PKT_CNT_W.
- Boundary cases:
  - in_last on lane RATIO-1 yields a full word with last=1, nlanes_m1=RATIO-1.
  - Single-beat packet yields nlanes_m1=0.
  - No idle word is emitted between packets.
- Idle: in_valid=0 causes no state change except the drain.
- Reset mid-packet: partial acc and any pending out_reg are discarded. The first beat after reset goes to lane 0.

Test Plan:
IN_WIDTH=4, RATIO=4.
1. Beats 1,2,3,4, in_last=0, fifo_full=0 -> one cycle after the 4th beat: fifo_wr_en=1, fifo_wr_data={1'b0,2'd3,16'h4321}; in_ready stays 1 throughout.
2. Beats A,B with in_last on B -> fifo_wr_data={1'b1,2'd1,16'h00BA}; pkt_cnt 0->1 in the cycle after the write.
3. fifo_full=1, 8 beats offered continuously -> 4 accepted; in_ready=0 from the cycle after the 4th; fifo_wr_en=0. Release fifo_full -> word 16'h4321 written that cycle; remaining beats resume; no beat lost or duplicated.
4. 16 back-to-back beats with fifo_full=0 -> 4 writes, one every 4 cycles, in_ready never low, data order preserved.
5. Single beat 7 with in_last -> {1'b1,2'd0,16'h0007}. Immediately followed by beats 1,2,3,4 -> next word {1'b0,2'd3,16'h4321}.
6. Assert wr_rst_n low after 2 beats of a packet, then release -> fifo_wr_en=0, pkt_cnt=0. Beats 5,6,7,8 then give {1'b0,2'd3,16'h8765}.
